training_sample_feeder: RTL

//  Upstream sequencer for the Training block. Holds a loadable table of (x1,x2,t) training

---
 rtl/training_sample_feeder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/training_sample_feeder.sv
// Training sample feeder: loadable (x1,x2,t) table, replayed per epoch.
// Ports: table write, run control, Training handshake, sample out,
// status. Optional cycle_cnt output with FEEDER_CYCLE_CNT_EN.
module training_sample_feeder #(
  parameter int XW        = 7,
  parameter int TW        = 2,
  parameter int AW        = 4,
  parameter int EW        = 6,
  parameter int MAX_EPOCH = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [XW-1:0] wr_x1,
  input  logic [XW-1:0] wr_x2,
  input  logic [TW-1:0] wr_t,
  input  logic [AW:0]   num_samples,
  input  logic          go,
  input  logic          abort,
  input  logic          ready,
  output logic [XW-1:0] x1,
  output logic [XW-1:0] x2,
  output logic [TW-1:0] t,
  output logic          Start,
  output logic          busy,
  output logic          done,
  output logic [EW-1:0] epoch_cnt
`ifdef FEEDER_CYCLE_CNT_EN
  ,
  output logic [15:0]   cycle_cnt
`endif
);

  localparam int DW    = 2*XW + TW;
  localparam int DEPTH = 2**AW;
  localparam logic [EW-1:0] MAXE = EW'(MAX_EPOCH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WACK,
    S_WDONE,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW:0]     ns_q, ns_d;
  logic [EW-1:0]   ep_q, ep_d;
  logic [DW-1:0]   x_q, x_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   rd;
  logic            wr_acc;
  logic            last;
  logic            ep_last;

  assign wr_acc  = wr_en && (state_q == S_IDLE);
  assign rd      = mem_q[idx_q];
  assign last    = ((AW+1)'(idx_q) + (AW+1)'(1)) >= ns_q;
  assign ep_last = (ep_q + EW'(1)) == MAXE;

  always_ff @(posedge Clk) begin
    if (wr_acc) begin
      mem_q[wr_addr] <= {wr_x1, wr_x2, wr_t};
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ns_d    = ns_q;
    ep_d    = ep_q;
    x_d     = x_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          ns_d    = num_samples;
          idx_d   = '0;
          ep_d    = '0;
          state_d = (num_samples == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          x_d     = rd;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          start_d = 1'b1;
          state_d = S_WACK;
        end
      end
      S_WACK: begin
        if (abort) begin
          state_d = S_DRAIN;
        end else if (!ready) begin
          state_d = S_WDONE;
        end
      end
      S_WDONE: begin
        if (abort) begin
          state_d = S_DRAIN;
        end else if (ready) begin
          if (!last) begin
            idx_d   = idx_q + AW'(1);
            state_d = S_LOAD;
          end else begin
            idx_d   = '0;
            ep_d    = ep_q + EW'(1);
            state_d = ep_last ? S_DONE : S_LOAD;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ns_q    <= '0;
      ep_q    <= '0;
      x_q     <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ns_q    <= ns_d;
      ep_q    <= ep_d;
      x_q     <= x_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign {x1, x2, t} = x_q;
  assign Start       = start_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign epoch_cnt   = ep_q;

`ifdef FEEDER_CYCLE_CNT_EN
  logic [15:0] cc_q, cc_d;

  always_comb begin
    cc_d = cc_q;
    if (state_q == S_IDLE) begin
      if (go) begin
        cc_d = '0;
      end
    end else if (cc_q != 16'hFFFF) begin
      cc_d = cc_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cc_q <= '0;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign cycle_cnt = cc_q;
`endif

endmodule
